tl_hdr_parse: RTL and testbench

//  Receive-side TLP header decoder. Accepts one 128-bit header per transfer from the RX link path,

---
 rtl/tl_pkg.sv | 51 +++++
 rtl/tl_hdr_parse.sv | 211 +++++++++++++++++++++
 tb/tb_tl_hdr_parse.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared TLP definitions: receive-side header kinds, Fmt/Type codes used by
// both the RX parser and the TX header generator, and the decoded-header struct.
package tl_pkg;

  typedef enum logic [2:0] {
    RX_MRD   = 3'd0,
    RX_MWR   = 3'd1,
    RX_CFGRD = 3'd2,
    RX_CFGWR = 3'd3,
    RX_CPL   = 3'd4,
    RX_CPLD  = 3'd5
  } tl_rx_kind_e;

  // Fmt/Type byte (DW0[31:24]) codes
  localparam logic [7:0] FT_MRD32  = 8'h00;
  localparam logic [7:0] FT_MRD64  = 8'h20;
  localparam logic [7:0] FT_MWR32  = 8'h40;
  localparam logic [7:0] FT_MWR64  = 8'h60;
  localparam logic [7:0] FT_CFGRD0 = 8'h04;
  localparam logic [7:0] FT_CFGWR0 = 8'h44;
  localparam logic [7:0] FT_CPL    = 8'h0A;
  localparam logic [7:0] FT_CPLD   = 8'h4A;

  // Parser FSM states, exported so checkers can observe them
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EMIT    = 2'd2,
    ST_RELEASE = 2'd3
  } tl_parse_state_e;

  typedef struct packed {
    tl_rx_kind_e kind;
    logic [10:0] len;
    logic [63:0] addr;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  first_be;
    logic [3:0]  last_be;
    logic [2:0]  cpl_status;
    logic [11:0] byte_cnt;
    logic [6:0]  lower_addr;
    logic        poisoned;
  } tl_rx_hdr_t;

  // Length field in DW; an encoded 0 means the maximum of 1024 DW
  function automatic logic [10:0] tl_len_dw(input logic [9:0] field);
    return (field == 10'd0) ? 11'd1024 : {1'b0, field};
  endfunction

endpackage

// File: rtl/tl_hdr_parse.sv
// Receive-side TLP header decoder. Registers one header, classifies and checks
// it in DECODE (including the Tag Table lookup for completions), presents the
// decoded header in EMIT, and frees the tag after the final completion.
//
// Handshakes: a header transfers on a rising edge where hdr_valid_i &&
// hdr_ready_o; a decoded header transfers on a rising edge where rx_valid_o &&
// rx_ready_i. rx_valid_o never drops and rx_* never change until that transfer.
module tl_hdr_parse
  import tl_pkg::*;
#(
  parameter int TAG_W             = 8,
  parameter int MAX_PAYLOAD_BYTES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     hdr_i,
  input  logic             hdr_valid_i,
  output logic             hdr_ready_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [2:0]       rx_kind_o,
  output logic [10:0]      rx_len_o,
  output logic [63:0]      rx_addr_o,
  output logic [15:0]      rx_req_id_o,
  output logic [7:0]       rx_tag_o,
  output logic [3:0]       rx_first_be_o,
  output logic [3:0]       rx_last_be_o,
  output logic [2:0]       rx_cpl_status_o,
  output logic [11:0]      rx_byte_cnt_o,
  output logic [6:0]       rx_lower_addr_o,
  output logic             rx_poisoned_o,
  output logic [TAG_W-1:0] tag_lookup_o,
  input  logic             tag_active_i,
  output logic             tag_free_o,
  output logic [TAG_W-1:0] tag_free_id_o,
  output logic             err_unsup_o,
  output logic             err_malformed_o,
  output logic             err_unexp_cpl_o,
  output logic [1:0]       dbg_state_o
);

  tl_parse_state_e state_q;
  logic [127:0]    hdr_q;
  tl_rx_hdr_t      rx_hdr_q;
  logic            rx_valid_q;
  logic            final_q;
  logic            tag_free_q;
  logic [TAG_W-1:0] tag_free_id_q;
  logic            err_unsup_q;
  logic            err_malformed_q;
  logic            err_unexp_q;

  // Decode results for the registered header
  tl_rx_hdr_t dec_d;
  logic [7:0]  ft;
  logic        supported;
  logic        is_4dw;
  logic        is_cfg;
  logic        is_cpl;
  logic        has_payload;
  logic [12:0] len_bytes;
  logic [12:0] byte_cnt13;
  logic [7:0]  tag_hi;
  logic        malformed_d;
  logic        unexp_d;
  logic        final_d;

  // Bits of the header the decoder intentionally ignores (TD, reserved, addr[1:0])
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{hdr_q[119:111], hdr_q[109:106], hdr_q[1:0]};

  assign ft = hdr_q[127:120];

  // Classify Fmt/Type and extract fields according to header format
  always_comb begin
    dec_d       = '0;
    supported   = 1'b0;
    is_4dw      = 1'b0;
    is_cfg      = 1'b0;
    is_cpl      = 1'b0;
    has_payload = 1'b0;
    case (ft)
      FT_MRD32:  begin supported = 1'b1; dec_d.kind = RX_MRD; end
      FT_MRD64:  begin supported = 1'b1; dec_d.kind = RX_MRD; is_4dw = 1'b1; end
      FT_MWR32:  begin supported = 1'b1; dec_d.kind = RX_MWR; has_payload = 1'b1; end
      FT_MWR64:  begin supported = 1'b1; dec_d.kind = RX_MWR; has_payload = 1'b1; is_4dw = 1'b1; end
      FT_CFGRD0: begin supported = 1'b1; dec_d.kind = RX_CFGRD; is_cfg = 1'b1; end
      FT_CFGWR0: begin supported = 1'b1; dec_d.kind = RX_CFGWR; is_cfg = 1'b1; end
      FT_CPL:    begin supported = 1'b1; dec_d.kind = RX_CPL; is_cpl = 1'b1; end
      FT_CPLD:   begin supported = 1'b1; dec_d.kind = RX_CPLD; is_cpl = 1'b1; has_payload = 1'b1; end
      default:   ;
    endcase
    dec_d.len      = tl_len_dw(hdr_q[105:96]);
    dec_d.poisoned = hdr_q[110];
    if (is_cpl) begin
      dec_d.cpl_status = hdr_q[79:77];
      dec_d.byte_cnt   = hdr_q[75:64];
      dec_d.req_id     = hdr_q[63:48];
      dec_d.tag        = hdr_q[47:40];
      dec_d.lower_addr = hdr_q[38:32];
    end else begin
      dec_d.req_id   = hdr_q[95:80];
      dec_d.tag      = hdr_q[79:72];
      dec_d.last_be  = hdr_q[71:68];
      dec_d.first_be = hdr_q[67:64];
      if (is_cfg) begin
        dec_d.addr = {32'h0, hdr_q[63:32]};
      end else if (is_4dw) begin
        dec_d.addr = {hdr_q[63:2], 2'b00};
      end else begin
        dec_d.addr = {32'h0, hdr_q[63:34], 2'b00};
      end
    end
  end

  // Length / tag checks and final-completion detection, all in 13-bit byte units
  always_comb begin
    len_bytes   = {dec_d.len, 2'b00};
    byte_cnt13  = (dec_d.byte_cnt == 12'd0) ? 13'd4096 : {1'b0, dec_d.byte_cnt};
    tag_hi      = dec_d.tag >> TAG_W;
    malformed_d = (has_payload && (len_bytes > 13'(MAX_PAYLOAD_BYTES))) ||
                  (is_cfg && (dec_d.len != 11'd1));
    unexp_d     = is_cpl && (!tag_active_i || (tag_hi != 8'd0));
    final_d     = is_cpl && ((dec_d.cpl_status != 3'd0) || (ft == FT_CPL) ||
                             (len_bytes >= byte_cnt13));
  end

  // Parser FSM with registered decoded header, error pulses and tag release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      hdr_q           <= '0;
      rx_hdr_q        <= '0;
      rx_valid_q      <= 1'b0;
      final_q         <= 1'b0;
      tag_free_q      <= 1'b0;
      tag_free_id_q   <= '0;
      err_unsup_q     <= 1'b0;
      err_malformed_q <= 1'b0;
      err_unexp_q     <= 1'b0;
    end else begin
      err_unsup_q     <= 1'b0;
      err_malformed_q <= 1'b0;
      err_unexp_q     <= 1'b0;
      tag_free_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hdr_valid_i) begin
            hdr_q   <= hdr_i;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!supported) begin
            err_unsup_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (malformed_d) begin
            err_malformed_q <= 1'b1;
            state_q         <= ST_IDLE;
          end else if (unexp_d) begin
            err_unexp_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            rx_hdr_q   <= dec_d;
            final_q    <= final_d;
            rx_valid_q <= 1'b1;
            state_q    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
            if (final_q) begin
              tag_free_q    <= 1'b1;
              tag_free_id_q <= rx_hdr_q.tag[TAG_W-1:0];
              state_q       <= ST_RELEASE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hdr_ready_o     = (state_q == ST_IDLE);
  assign tag_lookup_o    = (state_q == ST_DECODE) ? dec_d.tag[TAG_W-1:0] : '0;
  assign rx_valid_o      = rx_valid_q;
  assign rx_kind_o       = rx_hdr_q.kind;
  assign rx_len_o        = rx_hdr_q.len;
  assign rx_addr_o       = rx_hdr_q.addr;
  assign rx_req_id_o     = rx_hdr_q.req_id;
  assign rx_tag_o        = rx_hdr_q.tag;
  assign rx_first_be_o   = rx_hdr_q.first_be;
  assign rx_last_be_o    = rx_hdr_q.last_be;
  assign rx_cpl_status_o = rx_hdr_q.cpl_status;
  assign rx_byte_cnt_o   = rx_hdr_q.byte_cnt;
  assign rx_lower_addr_o = rx_hdr_q.lower_addr;
  assign rx_poisoned_o   = rx_hdr_q.poisoned;
  assign tag_free_o      = tag_free_q;
  assign tag_free_id_o   = tag_free_id_q;
  assign err_unsup_o     = err_unsup_q;
  assign err_malformed_o = err_malformed_q;
  assign err_unexp_cpl_o = err_unexp_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_tl_hdr_parse.sv
// Directed bench for tl_hdr_parse: inputs change and outputs are sampled on
// the falling clock edge; expected values are hand-computed constants.
module tb_tl_hdr_parse;
  import tl_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [127:0] hdr_i;
  logic         hdr_valid_i;
  logic         hdr_ready_o;
  logic         rx_valid_o;
  logic         rx_ready_i;
  logic [2:0]   rx_kind_o;
  logic [10:0]  rx_len_o;
  logic [63:0]  rx_addr_o;
  logic [15:0]  rx_req_id_o;
  logic [7:0]   rx_tag_o;
  logic [3:0]   rx_first_be_o;
  logic [3:0]   rx_last_be_o;
  logic [2:0]   rx_cpl_status_o;
  logic [11:0]  rx_byte_cnt_o;
  logic [6:0]   rx_lower_addr_o;
  logic         rx_poisoned_o;
  logic [7:0]   tag_lookup_o;
  logic         tag_active_i;
  logic         tag_free_o;
  logic [7:0]   tag_free_id_o;
  logic         err_unsup_o;
  logic         err_malformed_o;
  logic         err_unexp_cpl_o;
  logic [1:0]   dbg_state_o;

  int vectors;
  int miscompares;

  tl_hdr_parse #(.TAG_W(8), .MAX_PAYLOAD_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .hdr_i(hdr_i), .hdr_valid_i(hdr_valid_i),
    .hdr_ready_o(hdr_ready_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_kind_o(rx_kind_o), .rx_len_o(rx_len_o), .rx_addr_o(rx_addr_o),
    .rx_req_id_o(rx_req_id_o), .rx_tag_o(rx_tag_o), .rx_first_be_o(rx_first_be_o),
    .rx_last_be_o(rx_last_be_o), .rx_cpl_status_o(rx_cpl_status_o),
    .rx_byte_cnt_o(rx_byte_cnt_o), .rx_lower_addr_o(rx_lower_addr_o),
    .rx_poisoned_o(rx_poisoned_o), .tag_lookup_o(tag_lookup_o),
    .tag_active_i(tag_active_i), .tag_free_o(tag_free_o), .tag_free_id_o(tag_free_id_o),
    .err_unsup_o(err_unsup_o), .err_malformed_o(err_malformed_o),
    .err_unexp_cpl_o(err_unexp_cpl_o), .dbg_state_o(dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header builders
  function automatic logic [127:0] mk_req(input logic [7:0] ft, input logic [9:0] len,
                                          input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [3:0] lbe, input logic [3:0] fbe,
                                          input logic [63:0] a);
    logic [127:0] h;
    h = '0;
    h[127:120] = ft; h[105:96] = len; h[95:80] = rid; h[79:72] = tag;
    h[71:68] = lbe;  h[67:64] = fbe;
    if (ft[5]) h[63:0] = a;
    else       h[63:32] = a[31:0];
    return h;
  endfunction

  function automatic logic [127:0] mk_cpl(input logic [7:0] ft, input logic [9:0] len,
                                          input logic [2:0] st, input logic [11:0] bc,
                                          input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [6:0] lo, input logic ep);
    logic [127:0] h;
    h = '0;
    h[127:120] = ft; h[110] = ep; h[105:96] = len; h[95:80] = 16'hC0DE;
    h[79:77] = st; h[75:64] = bc; h[63:48] = rid; h[47:40] = tag; h[38:32] = lo;
    return h;
  endfunction

  // Driver: present a header in IDLE; returns at the falling edge of the DECODE cycle
  task automatic drive_hdr(input logic [127:0] h);
    @(negedge clk);
    hdr_i = h;
    hdr_valid_i = 1'b1;
    @(negedge clk);
    hdr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hdr_valid_i = 1'b0; hdr_i = '0; rx_ready_i = 1'b0; tag_active_i = 1'b0;
    #12;
    if ({rx_valid_o, rx_kind_o, rx_len_o, rx_addr_o, rx_req_id_o, rx_tag_o, rx_first_be_o,
         rx_last_be_o, rx_cpl_status_o, rx_byte_cnt_o, rx_lower_addr_o, rx_poisoned_o,
         tag_lookup_o, tag_free_o, tag_free_id_o, err_unsup_o, err_malformed_o,
         err_unexp_cpl_o, dbg_state_o} !== '0 || hdr_ready_o !== 1'b1) begin
      $display("FAIL reset_outputs: hdr_ready=%b rx_valid=%b state=%0d want all 0 and hdr_ready=1",
               hdr_ready_o, rx_valid_o, dbg_state_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cpld_final();
    tag_active_i = 1'b1;
    drive_hdr(mk_cpl(FT_CPLD, 10'd4, 3'd0, 12'd16, 16'hABCD, 8'd5, 7'h10, 1'b0));
    if (tag_lookup_o !== 8'd5 || hdr_ready_o !== 1'b0) begin
      $display("FAIL cpld_lookup: tag_lookup=%0d hdr_ready=%b want 5 0", tag_lookup_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    if ({rx_valid_o, rx_kind_o, rx_len_o, rx_tag_o, rx_req_id_o, rx_byte_cnt_o, rx_lower_addr_o, rx_addr_o}
        !== {1'b1, 3'd5, 11'd4, 8'd5, 16'hABCD, 12'd16, 7'h10, 64'h0}) begin
      $display("FAIL cpld_emit: valid=%b kind=%0d len=%0d tag=%0d rid=%h bc=%0d lo=%h want 1 5 4 5 abcd 16 10",
               rx_valid_o, rx_kind_o, rx_len_o, rx_tag_o, rx_req_id_o, rx_byte_cnt_o, rx_lower_addr_o);
      miscompares++;
    end
    vectors++;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    if ({tag_free_o, tag_free_id_o, rx_valid_o, hdr_ready_o} !== {1'b1, 8'd5, 1'b0, 1'b0}) begin
      $display("FAIL cpld_free: free=%b id=%0d valid=%b hdr_ready=%b want 1 5 0 0",
               tag_free_o, tag_free_id_o, rx_valid_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    if ({tag_free_o, hdr_ready_o} !== 2'b01) begin
      $display("FAIL cpld_free_once: free=%b hdr_ready=%b want 0 1", tag_free_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_cpld_partial();
    tag_active_i = 1'b1;
    // 16 bytes delivered of 64 remaining: not the last completion
    drive_hdr(mk_cpl(FT_CPLD, 10'd4, 3'd0, 12'd64, 16'h0001, 8'd5, 7'h00, 1'b1));
    @(negedge clk);
    if ({rx_valid_o, rx_kind_o, rx_poisoned_o, rx_byte_cnt_o} !== {1'b1, 3'd5, 1'b1, 12'd64}) begin
      $display("FAIL partial_emit: valid=%b kind=%0d ep=%b bc=%0d want 1 5 1 64",
               rx_valid_o, rx_kind_o, rx_poisoned_o, rx_byte_cnt_o);
      miscompares++;
    end
    vectors++;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    if ({tag_free_o, hdr_ready_o} !== 2'b01) begin
      $display("FAIL partial_no_free: free=%b hdr_ready=%b want 0 1", tag_free_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    // 48 bytes delivered of 48 remaining: last completion
    drive_hdr(mk_cpl(FT_CPLD, 10'd12, 3'd0, 12'd48, 16'h0001, 8'd5, 7'h00, 1'b0));
    @(negedge clk);
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    if ({tag_free_o, tag_free_id_o} !== {1'b1, 8'd5}) begin
      $display("FAIL partial_last_free: free=%b id=%0d want 1 5", tag_free_o, tag_free_id_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    // Non-zero status ends the request even with bytes outstanding
    drive_hdr(mk_cpl(FT_CPLD, 10'd4, 3'd1, 12'd64, 16'h0001, 8'd6, 7'h00, 1'b0));
    @(negedge clk);
    if ({rx_valid_o, rx_cpl_status_o} !== {1'b1, 3'd1}) begin
      $display("FAIL status_emit: valid=%b status=%0d want 1 1", rx_valid_o, rx_cpl_status_o);
      miscompares++;
    end
    vectors++;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    if ({tag_free_o, tag_free_id_o} !== {1'b1, 8'd6}) begin
      $display("FAIL status_free: free=%b id=%0d want 1 6", tag_free_o, tag_free_id_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
  endtask

  task automatic test_unexp_cpl();
    tag_active_i = 1'b0;
    drive_hdr(mk_cpl(FT_CPL, 10'd0, 3'd0, 12'd4, 16'h0002, 8'd9, 7'h00, 1'b0));
    if (tag_lookup_o !== 8'd9) begin
      $display("FAIL unexp_lookup: tag_lookup=%0d want 9", tag_lookup_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o} !== 4'b0010) begin
      $display("FAIL unexp_pulse: unsup/malf/unexp/valid=%b%b%b%b want 0010",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o, tag_free_o, hdr_ready_o} !== 6'b000001) begin
      $display("FAIL unexp_after: unsup/malf/unexp/valid/free/ready=%b%b%b%b%b%b want 000001",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o, tag_free_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    // Oversized CplD for an inactive tag: the length error wins
    drive_hdr(mk_cpl(FT_CPLD, 10'd65, 3'd0, 12'd260, 16'h0002, 8'd9, 7'h00, 1'b0));
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o} !== 4'b0100) begin
      $display("FAIL prio_malf_over_unexp: unsup/malf/unexp/valid=%b%b%b%b want 0100",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
  endtask

  task automatic test_mwr64();
    drive_hdr(mk_req(FT_MWR64, 10'd64, 16'h0100, 8'h22, 4'hF, 4'hF, 64'h1_0000_0040));
    @(negedge clk);
    if ({rx_valid_o, rx_kind_o, rx_len_o, rx_addr_o, rx_req_id_o, rx_tag_o, rx_last_be_o, rx_first_be_o}
        !== {1'b1, 3'd1, 11'd64, 64'h1_0000_0040, 16'h0100, 8'h22, 4'hF, 4'hF}) begin
      $display("FAIL mwr64_emit: valid=%b kind=%0d len=%0d addr=%h rid=%h tag=%h want 1 1 64 100000040 0100 22",
               rx_valid_o, rx_kind_o, rx_len_o, rx_addr_o, rx_req_id_o, rx_tag_o);
      miscompares++;
    end
    vectors++;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    if ({tag_free_o, hdr_ready_o, rx_valid_o} !== 3'b010) begin
      $display("FAIL mwr64_done: free=%b hdr_ready=%b valid=%b want 0 1 0", tag_free_o, hdr_ready_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    drive_hdr(mk_req(FT_MWR64, 10'd65, 16'h0100, 8'h23, 4'hF, 4'hF, 64'h1_0000_0040));
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o} !== 4'b0100) begin
      $display("FAIL mwr64_malformed: unsup/malf/unexp/valid=%b%b%b%b want 0100",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    // Length field 0 means 1024 DW: far beyond the payload limit
    drive_hdr(mk_req(FT_MWR32, 10'd0, 16'h0100, 8'h24, 4'hF, 4'hF, 64'h0000_1000));
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o} !== 4'b0100) begin
      $display("FAIL mwr32_len0_malformed: unsup/malf/unexp/valid=%b%b%b%b want 0100",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    drive_hdr(mk_req(FT_CFGWR0, 10'd2, 16'h0100, 8'h25, 4'h0, 4'hF, 64'h0000_0010));
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o} !== 4'b0100) begin
      $display("FAIL cfgwr_len2_malformed: unsup/malf/unexp/valid=%b%b%b%b want 0100",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
  endtask

  task automatic test_unsup_backpressure();
    logic [127:0] h;
    h = mk_req(8'h30, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF, 64'h0);
    drive_hdr(h);
    @(negedge clk);
    if ({err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o} !== 4'b1000) begin
      $display("FAIL unsup_pulse: unsup/malf/unexp/valid=%b%b%b%b want 1000",
               err_unsup_o, err_malformed_o, err_unexp_cpl_o, rx_valid_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    drive_hdr(mk_req(FT_MRD32, 10'd2, 16'h4321, 8'h7E, 4'hF, 4'h1, 64'h1234_567B));
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if ({rx_valid_o, hdr_ready_o, rx_kind_o, rx_len_o, rx_addr_o, rx_req_id_o, rx_tag_o, rx_first_be_o}
          !== {1'b1, 1'b0, 3'd0, 11'd2, 64'h1234_5678, 16'h4321, 8'h7E, 4'h1}) begin
        $display("FAIL mrd_stall_%0d: valid=%b ready=%b kind=%0d len=%0d addr=%h rid=%h tag=%h want 1 0 0 2 12345678 4321 7e",
                 i, rx_valid_o, hdr_ready_o, rx_kind_o, rx_len_o, rx_addr_o, rx_req_id_o, rx_tag_o);
        miscompares++;
      end
      vectors++;
      if (i == 5) rx_ready_i = 1'b1;
      @(negedge clk);
    end
    rx_ready_i = 1'b0;
    if ({rx_valid_o, hdr_ready_o, tag_free_o} !== 3'b010) begin
      $display("FAIL mrd_accepted: valid=%b ready=%b free=%b want 0 1 0", rx_valid_o, hdr_ready_o, tag_free_o);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    hdr_i = mk_req(FT_CFGRD0, 10'd1, 16'h0011, 8'h33, 4'h0, 4'hF, 64'h0100_0A0C);
    hdr_valid_i = 1'b1;
    rx_ready_i = 1'b1;
    @(negedge clk);
    hdr_i = mk_req(FT_MRD32, 10'd0, 16'h0022, 8'h44, 4'hF, 4'hF, 64'hDEAD_BEEF);
    @(negedge clk);
    if ({rx_valid_o, rx_kind_o, rx_addr_o, rx_len_o, hdr_ready_o} !== {1'b1, 3'd2, 64'h0100_0A0C, 11'd1, 1'b0}) begin
      $display("FAIL b2b_cfgrd: valid=%b kind=%0d addr=%h len=%0d ready=%b want 1 2 01000a0c 1 0",
               rx_valid_o, rx_kind_o, rx_addr_o, rx_len_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    if ({rx_valid_o, hdr_ready_o} !== 2'b01) begin
      $display("FAIL b2b_gap: valid=%b ready=%b want 0 1", rx_valid_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    hdr_valid_i = 1'b0;
    @(negedge clk);
    if ({rx_valid_o, rx_kind_o, rx_addr_o, rx_len_o, rx_tag_o} !== {1'b1, 3'd0, 64'hDEAD_BEEC, 11'd1024, 8'h44}) begin
      $display("FAIL b2b_mrd: valid=%b kind=%0d addr=%h len=%0d tag=%h want 1 0 deadbeec 1024 44",
               rx_valid_o, rx_kind_o, rx_addr_o, rx_len_o, rx_tag_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset_in_emit();
    tag_active_i = 1'b1;
    drive_hdr(mk_cpl(FT_CPLD, 10'd1, 3'd0, 12'd4, 16'h0003, 8'd7, 7'h04, 1'b0));
    @(negedge clk);
    if (rx_valid_o !== 1'b1) begin
      $display("FAIL rst_emit_valid: valid=%b want 1", rx_valid_o);
      miscompares++;
    end
    vectors++;
    rst_n = 1'b0;
    #1;
    if ({rx_valid_o, rx_kind_o, rx_len_o, rx_tag_o, rx_byte_cnt_o, tag_free_o, tag_free_id_o, dbg_state_o} !== '0
        || hdr_ready_o !== 1'b1) begin
      $display("FAIL rst_emit_clear: valid=%b kind=%0d tag=%0d free=%b ready=%b want 0 0 0 0 1",
               rx_valid_o, rx_kind_o, rx_tag_o, tag_free_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    @(negedge clk);
    rst_n = 1'b1;
    rx_ready_i = 1'b1;
    @(negedge clk);
    if ({tag_free_o, rx_valid_o, hdr_ready_o} !== 3'b001) begin
      $display("FAIL rst_no_free: free=%b valid=%b ready=%b want 0 0 1", tag_free_o, rx_valid_o, hdr_ready_o);
      miscompares++;
    end
    vectors++;
    rx_ready_i = 1'b0;
    drive_hdr(mk_req(FT_MRD64, 10'd8, 16'h0055, 8'h66, 4'hF, 4'hF, 64'hFFFF_0000_1234_5677));
    @(negedge clk);
    if ({rx_valid_o, rx_kind_o, rx_len_o, rx_addr_o, rx_tag_o} !== {1'b1, 3'd0, 11'd8, 64'hFFFF_0000_1234_5674, 8'h66}) begin
      $display("FAIL rst_next_hdr: valid=%b kind=%0d len=%0d addr=%h tag=%h want 1 0 8 ffff000012345674 66",
               rx_valid_o, rx_kind_o, rx_len_o, rx_addr_o, rx_tag_o);
      miscompares++;
    end
    vectors++;
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_cpld_final();
    test_cpld_partial();
    test_unexp_cpl();
    test_mwr64();
    test_unsup_backpressure();
    test_back_to_back();
    test_reset_in_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
